morph_filter_3x3: RTL and testbench
===================================

MORPH_FILTER_3X3 -- requirements
Module: morph_filter_3x3

Interface
REQ-001 SHALL have parameter N, default 1, pixel bit width (1 = binary morphology, >1 = grayscale min/max).
REQ-002 SHALL have parameter LAT, default 2, fixed input-to-output latency in cycles; only value 2 is supported.
REQ-003 SHALL have port clock, input, 1, rising-edge clock for all state.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port width, input, 16, image width in pixels, static during a frame.
REQ-006 SHALL have port height, input, 16, image height in lines, static during a frame.
REQ-007 SHALL have port mode, input, 1, operation select: 0 = erode (min), 1 = dilate (max).
REQ-008 SHALL have ports p00..p22, input, N each, 3x3 window from the upstream window generator; p11 is the centre.
REQ-009 SHALL have port valid_in, input, 1, window valid qualifier; one window is consumed per cycle while high.
REQ-010 SHALL have port po, output, N, filtered centre pixel.
REQ-011 SHALL have port valid_out, output, 1, po qualifier.
REQ-012 SHALL have port eof, output, 1, one-cycle pulse coincident with valid_out of the last pixel of a frame.

Function
REQ-013 SHALL keep column counter col (0..width-1) and row counter row (0..height-1) that advance only on valid_in.
- col wraps to 0 after width-1, and row increments at that point.
- row wraps to 0 after height-1 with col wrap, and the frame ends at that point.
REQ-014 SHALL latch mode into mode_q on the valid_in cycle where col=0 and row=0; mode changes mid-frame have no effect until the next frame.
REQ-015 SHALL treat a window as border when col=0, col=width-1, row=0 or row=height-1; width<3 or height<3 makes every window border.
REQ-016 Stage 1 SHALL register three row results.
- Erode: min(px0,px1,px2) per row x.
- Dilate: max(px0,px1,px2) per row x.
- Stage 1 also registers p11, the border flag and the eof flag.
REQ-017 Stage 2 SHALL register po as the min/max of the three stage-1 row results, or the border value for border windows.
REQ-018 valid_out SHALL equal valid_in delayed exactly 2 cycles; gaps in valid_in SHALL propagate unchanged.
REQ-019 Pipeline registers SHALL advance every cycle; no backpressure exists, and the downstream stage accepts every valid_out.
REQ-020 po SHALL hold its last value while valid_out is low.
REQ-021 Comparisons SHALL be unsigned N-bit; no width growth.
REQ-022 If valid_in is high on the last pixel of frame k and the first pixel of frame k+1 in consecutive cycles, both SHALL be processed without a gap, and mode_q SHALL update for frame k+1 only.

Reset
REQ-023 On reset_n low at a clock edge, the block SHALL clear col, row, mode_q, all stage valids, eof and po to 0.
REQ-024 Reset mid-frame SHALL discard in-flight windows; the first valid_in after reset SHALL be treated as col=0, row=0.

Configuration
REQ-025 Macro MORPH_BORDER_CLEAR_EN SHALL control the border value.
- When defined, border windows output po=0.
- When undefined, border windows output po=p11 (pass-through).
- Latency and valid timing are identical in both builds.

Structure
REQ-026 Package morph_pkg SHALL hold MODE_ERODE=1'b0, MODE_DILATE=1'b1 and the latency constant MORPH_LAT=2.
REQ-027 Sub-module morph_minmax3 SHALL be a combinational three-input unsigned min/max selector with parameter N and select input.
- It is instantiated 3 times in stage 1 and once in stage 2.

Verification
REQ-028 The bench SHALL cover a binary erode on an 8x8 frame with a 4x4 block of 1s at rows/cols 2..5.
- Expected output: 1 only at rows/cols 3..4.
- Border outputs 0 in both builds for this image.
- 64 valid_out, eof on the 64th.
REQ-029 The bench SHALL cover a binary dilate on an 8x8 frame with a single 1 at (3,3).
- Expected output: 1s at rows/cols 2..4 (9 pixels), all others 0.
REQ-030 The bench SHALL cover an N=8 erode with a window of values 9,8,7,6,5,4,3,2,1 at an interior position.
- Expected: po=1 exactly 2 cycles after valid_in.
- In dilate mode: po=9.
REQ-031 The bench SHALL cover valid_in held low for 5 cycles mid-line.
- Required: valid_out low for the same 5 cycles, 2 cycles later.
- col/row unchanged during the gap, output image identical to the ungapped run.
REQ-032 The bench SHALL cover toggling mode from 0 to 1 at pixel 20 of frame 1.
- Required: frame 1 is entirely eroded; frame 2 is dilated.
REQ-033 The bench SHALL cover reset_n low for 1 cycle at pixel 30.
- Required: valid_out low the following 2 cycles.
- The next input is treated as (0,0).
- eof is asserted after 64 further pixels.

Source files
------------

// File: rtl/morph_pkg.sv
// rtl/morph_pkg.sv - shared constants for the 3x3 morphology filter
package morph_pkg;

    localparam logic MODE_ERODE  = 1'b0;
    localparam logic MODE_DILATE = 1'b1;
    localparam int   MORPH_LAT   = 2;

endpackage

// File: rtl/morph_filter_3x3_if.sv
// rtl/morph_filter_3x3_if.sv - window-in / pixel-out bus of the 3x3 morphology filter
interface morph_filter_3x3_if #(
    parameter int N = 1
) ();

    logic         valid_in;
    logic [N-1:0] p00, p01, p02;
    logic [N-1:0] p10, p11, p12;
    logic [N-1:0] p20, p21, p22;
    logic [N-1:0] po;
    logic         valid_out;
    logic         eof;

    modport master (
        output valid_in,
        output p00, p01, p02, p10, p11, p12, p20, p21, p22,
        input  po, valid_out, eof
    );

    modport slave (
        input  valid_in,
        input  p00, p01, p02, p10, p11, p12, p20, p21, p22,
        output po, valid_out, eof
    );

endinterface

// File: rtl/morph_minmax3.sv
// rtl/morph_minmax3.sv - combinational unsigned min (erode) / max (dilate) of three values
module morph_minmax3
    import morph_pkg::*;
#(
    parameter int N = 1
) (
    input  logic         sel,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    output logic [N-1:0] y
);

    logic [N-1:0] w_ab;

    always_comb begin
        w_ab = a;
        y    = a;
        if (sel == MODE_DILATE) begin
            w_ab = (a > b) ? a : b;
            y    = (w_ab > c) ? w_ab : c;
        end else begin
            w_ab = (a < b) ? a : b;
            y    = (w_ab < c) ? w_ab : c;
        end
    end

endmodule

// File: rtl/morph_filter_3x3.sv
// rtl/morph_filter_3x3.sv - 2-stage 3x3 erode/dilate filter; MORPH_BORDER_CLEAR_EN zeroes border pixels
module morph_filter_3x3
    import morph_pkg::*;
#(
    parameter int N   = 1,
    parameter int LAT = MORPH_LAT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [15:0]       width,
    input  logic [15:0]       height,
    input  logic              mode,
    morph_filter_3x3_if.slave bus
);

    if (LAT != MORPH_LAT) begin : g_lat_unsupported
        $error("morph_filter_3x3: only LAT=2 is supported");
    end

    logic [15:0]  r_col;
    logic [15:0]  r_row;
    logic         r_mode_q;

    logic         w_first;
    logic         w_mode;
    logic         w_col_last;
    logic         w_row_last;
    logic         w_border;
    logic         w_eof;

    logic [N-1:0] w_row0, w_row1, w_row2;
    logic [N-1:0] w_s2;
    logic [N-1:0] w_border_val;

    logic         r_s1_valid;
    logic [N-1:0] r_s1_row0, r_s1_row1, r_s1_row2;
    logic         r_s1_border;
    logic         r_s1_eof;
    logic         r_s1_mode;

    logic         r_valid_out;
    logic         r_eof;
    logic [N-1:0] r_po;

    // The first window of a frame uses the live mode input so back-to-back frames switch cleanly
    assign w_first    = (r_col == 16'd0) && (r_row == 16'd0);
    assign w_mode     = w_first ? mode : r_mode_q;
    assign w_col_last = (r_col == width - 16'd1);
    assign w_row_last = (r_row == height - 16'd1);
    assign w_border   = (r_col == 16'd0) || w_col_last || (r_row == 16'd0) || w_row_last ||
                        (width < 16'd3) || (height < 16'd3);
    assign w_eof      = w_col_last && w_row_last;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_col    <= 16'd0;
            r_row    <= 16'd0;
            r_mode_q <= MODE_ERODE;
        end else if (bus.valid_in) begin
            if (w_first) begin
                r_mode_q <= mode;
            end
            if (w_col_last) begin
                r_col <= 16'd0;
                r_row <= w_row_last ? 16'd0 : r_row + 16'd1;
            end else begin
                r_col <= r_col + 16'd1;
            end
        end
    end

    morph_minmax3 #(.N(N)) u_row0 (.sel(w_mode), .a(bus.p00), .b(bus.p01), .c(bus.p02), .y(w_row0));
    morph_minmax3 #(.N(N)) u_row1 (.sel(w_mode), .a(bus.p10), .b(bus.p11), .c(bus.p12), .y(w_row1));
    morph_minmax3 #(.N(N)) u_row2 (.sel(w_mode), .a(bus.p20), .b(bus.p21), .c(bus.p22), .y(w_row2));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_row0   <= '0;
            r_s1_row1   <= '0;
            r_s1_row2   <= '0;
            r_s1_border <= 1'b0;
            r_s1_eof    <= 1'b0;
            r_s1_mode   <= MODE_ERODE;
        end else begin
            r_s1_valid  <= bus.valid_in;
            r_s1_row0   <= w_row0;
            r_s1_row1   <= w_row1;
            r_s1_row2   <= w_row2;
            r_s1_border <= w_border;
            r_s1_eof    <= bus.valid_in && w_eof;
            r_s1_mode   <= w_mode;
        end
    end

`ifdef MORPH_BORDER_CLEAR_EN
    assign w_border_val = '0;
`else
    logic [N-1:0] r_s1_p11;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_s1_p11 <= '0;
        end else begin
            r_s1_p11 <= bus.p11;
        end
    end

    assign w_border_val = r_s1_p11;
`endif

    morph_minmax3 #(.N(N)) u_col (.sel(r_s1_mode), .a(r_s1_row0), .b(r_s1_row1), .c(r_s1_row2), .y(w_s2));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_valid_out <= 1'b0;
            r_eof       <= 1'b0;
            r_po        <= '0;
        end else begin
            r_valid_out <= r_s1_valid;
            r_eof       <= r_s1_valid && r_s1_eof;
            if (r_s1_valid) begin
                r_po <= r_s1_border ? w_border_val : w_s2;
            end
        end
    end

    assign bus.po        = r_po;
    assign bus.valid_out = r_valid_out;
    assign bus.eof       = r_eof;

endmodule

// File: tb/tb_morph_filter_3x3.sv
// tb/tb_morph_filter_3x3.sv - scoreboard bench for binary and 8-bit morph_filter_3x3
module tb_morph_filter_3x3;

    typedef struct {
        logic [7:0] po;
        logic       eof;
    } exp_t;

    bit          clock = 1'b0;
    logic        reset_n;
    logic [15:0] width;
    logic [15:0] height;
    logic        mode_b;
    logic        mode_g;

    logic [7:0]  img [8][8];
    exp_t        q_b[$];
    exp_t        q_g[$];
    exp_t        eb_m;
    exp_t        eg_m;

    int tests_run    = 0;
    int tests_failed = 0;
    int vo_b = 0, eof_b = 0, vo_g = 0, eof_g = 0;

    bit         mon_en = 1'b0;
    bit         hr = 1'b0;
    bit         hb1 = 1'b0, hb2 = 1'b0, hg1 = 1'b0, hg2 = 1'b0;
    logic       prev_b;
    logic [7:0] prev_g;

    always #5 clock = ~clock;

    morph_filter_3x3_if #(.N(1)) bus_b ();
    morph_filter_3x3_if #(.N(8)) bus_g ();

    morph_filter_3x3 #(.N(1), .LAT(2)) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .width   (width),
        .height  (height),
        .mode    (mode_b),
        .bus     (bus_b)
    );

    morph_filter_3x3 #(.N(8), .LAT(2)) dut_g (
        .clock   (clock),
        .reset_n (reset_n),
        .width   (width),
        .height  (height),
        .mode    (mode_g),
        .bus     (bus_g)
    );

    // Reference valid pipeline: valid_out must be valid_in two edges back, wiped by reset
    always @(posedge clock) begin
        hr  <= reset_n;
        hb1 <= bus_b.valid_in && reset_n;
        hb2 <= reset_n ? hb1 : 1'b0;
        hg1 <= bus_g.valid_in && reset_n;
        hg2 <= reset_n ? hg1 : 1'b0;
    end

    always @(negedge clock) begin
        if (mon_en) begin
            tests_run++;
            if (bus_b.valid_out !== hb2) begin
                tests_failed++;
                $display("FAIL valid_delay_b: valid_out=%0b expected=%0b t=%0t", bus_b.valid_out, hb2, $time);
            end
            if (bus_b.valid_out === 1'b1) begin
                vo_b++;
                if (bus_b.eof === 1'b1) eof_b++;
                tests_run++;
                if (q_b.size() == 0) begin
                    tests_failed++;
                    $display("FAIL scoreboard_b: unexpected output po=%0d t=%0t", bus_b.po, $time);
                end else begin
                    eb_m = q_b.pop_front();
                    if ({7'd0, bus_b.po} !== eb_m.po || bus_b.eof !== eb_m.eof) begin
                        tests_failed++;
                        $display("FAIL scoreboard_b: po=%0d eof=%0b expected po=%0d eof=%0b t=%0t",
                                 bus_b.po, bus_b.eof, eb_m.po, eb_m.eof, $time);
                    end
                end
            end else begin
                tests_run++;
                if (bus_b.po !== (hr ? prev_b : 1'b0) || bus_b.eof !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL hold_b: po=%0d eof=%0b expected po=%0d eof=0 t=%0t",
                             bus_b.po, bus_b.eof, (hr ? prev_b : 1'b0), $time);
                end
            end
            prev_b = bus_b.po;

            tests_run++;
            if (bus_g.valid_out !== hg2) begin
                tests_failed++;
                $display("FAIL valid_delay_g: valid_out=%0b expected=%0b t=%0t", bus_g.valid_out, hg2, $time);
            end
            if (bus_g.valid_out === 1'b1) begin
                vo_g++;
                if (bus_g.eof === 1'b1) eof_g++;
                tests_run++;
                if (q_g.size() == 0) begin
                    tests_failed++;
                    $display("FAIL scoreboard_g: unexpected output po=%0d t=%0t", bus_g.po, $time);
                end else begin
                    eg_m = q_g.pop_front();
                    if (bus_g.po !== eg_m.po || bus_g.eof !== eg_m.eof) begin
                        tests_failed++;
                        $display("FAIL scoreboard_g: po=%0d eof=%0b expected po=%0d eof=%0b t=%0t",
                                 bus_g.po, bus_g.eof, eg_m.po, eg_m.eof, $time);
                    end
                end
            end else begin
                tests_run++;
                if (bus_g.po !== (hr ? prev_g : 8'd0) || bus_g.eof !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL hold_g: po=%0d eof=%0b expected po=%0d eof=0 t=%0t",
                             bus_g.po, bus_g.eof, (hr ? prev_g : 8'd0), $time);
                end
            end
            prev_g = bus_g.po;
        end
    end

    task automatic put_b(input logic [8:0][7:0] wv);
        bus_b.p00 = wv[0][0]; bus_b.p01 = wv[1][0]; bus_b.p02 = wv[2][0];
        bus_b.p10 = wv[3][0]; bus_b.p11 = wv[4][0]; bus_b.p12 = wv[5][0];
        bus_b.p20 = wv[6][0]; bus_b.p21 = wv[7][0]; bus_b.p22 = wv[8][0];
        bus_b.valid_in = 1'b1;
    endtask

    task automatic put_g(input logic [8:0][7:0] wv);
        bus_g.p00 = wv[0]; bus_g.p01 = wv[1]; bus_g.p02 = wv[2];
        bus_g.p10 = wv[3]; bus_g.p11 = wv[4]; bus_g.p12 = wv[5];
        bus_g.p20 = wv[6]; bus_g.p21 = wv[7]; bus_g.p22 = wv[8];
        bus_g.valid_in = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            bus_b.valid_in = 1'b0;
            bus_g.valid_in = 1'b0;
        end
    endtask

    // Drives one 8x8 frame; the expected model always uses the mode present at pixel 0
    task automatic drive_frame(input bit gray, input bit fmode, input int switch_px,
                               input int gap_px, input int gap_len, input int stop_px);
        logic [8:0][7:0] wv;
        logic [7:0]      acc;
        exp_t            e;
        bit              border;
        int              r, c, rr, cc;
        for (int px = 0; px < stop_px; px++) begin
            if (px == gap_px) idle(gap_len);
            @(posedge clock);
            #1;
            r = px / 8;
            c = px % 8;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    rr = r + i - 1;
                    cc = c + j - 1;
                    if (gray) wv[3*i+j] = 8'(9 - (3*i + j));
                    else if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) wv[3*i+j] = img[rr][cc];
                    else wv[3*i+j] = 8'd0;
                end
            end
            acc = wv[0];
            for (int k = 1; k < 9; k++) begin
                if (fmode) acc = (wv[k] > acc) ? wv[k] : acc;
                else       acc = (wv[k] < acc) ? wv[k] : acc;
            end
            border = (r == 0) || (r == 7) || (c == 0) || (c == 7);
`ifdef MORPH_BORDER_CLEAR_EN
            e.po = border ? 8'd0 : acc;
`else
            e.po = border ? wv[4] : acc;
`endif
            e.eof = (px == 63);
            if (gray) begin
                mode_g = (px >= switch_px) ? ~fmode : fmode;
                put_g(wv);
                q_g.push_back(e);
            end else begin
                mode_b = (px >= switch_px) ? ~fmode : fmode;
                put_b(wv);
                q_b.push_back(e);
            end
        end
    endtask

    task automatic clear_img();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                img[r][c] = 8'd0;
    endtask

    task automatic load_block();
        clear_img();
        for (int r = 2; r <= 5; r++)
            for (int c = 2; c <= 5; c++)
                img[r][c] = 8'd1;
    endtask

    task automatic check_frame_counts(input string name, input bit gray, input int exp_vo, input int exp_eof);
        tests_run++;
        if (gray ? (vo_g != exp_vo || eof_g != exp_eof || q_g.size() != 0)
                 : (vo_b != exp_vo || eof_b != exp_eof || q_b.size() != 0)) begin
            tests_failed++;
            $display("FAIL %s: valid_out=%0d eof=%0d pending=%0d expected valid_out=%0d eof=%0d pending=0",
                     name, gray ? vo_g : vo_b, gray ? eof_g : eof_b,
                     gray ? q_g.size() : q_b.size(), exp_vo, exp_eof);
        end
        vo_b = 0; eof_b = 0; vo_g = 0; eof_g = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        tests_run++;
        if (bus_b.po !== 1'b0 || bus_b.valid_out !== 1'b0 || bus_b.eof !== 1'b0 ||
            bus_g.po !== 8'd0 || bus_g.valid_out !== 1'b0 || bus_g.eof !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: b po=%0d v=%0b eof=%0b g po=%0d v=%0b eof=%0b expected all 0",
                     bus_b.po, bus_b.valid_out, bus_b.eof, bus_g.po, bus_g.valid_out, bus_g.eof);
        end
        mon_en  = 1'b1;
        reset_n = 1'b1;
    endtask

    task automatic test_erode_block();
        load_block();
        drive_frame(1'b0, 1'b0, 64, -1, 0, 64);
        idle(4);
        check_frame_counts("erode_block", 1'b0, 64, 1);
    endtask

    task automatic test_dilate_point();
        clear_img();
        img[3][3] = 8'd1;
        drive_frame(1'b0, 1'b1, 64, -1, 0, 64);
        idle(4);
        check_frame_counts("dilate_point", 1'b0, 64, 1);
    endtask

    task automatic test_gray_minmax();
        drive_frame(1'b1, 1'b0, 64, -1, 0, 64);
        idle(4);
        check_frame_counts("gray_erode", 1'b1, 64, 1);
        drive_frame(1'b1, 1'b1, 64, -1, 0, 64);
        idle(4);
        check_frame_counts("gray_dilate", 1'b1, 64, 1);
    endtask

    task automatic test_gap();
        load_block();
        drive_frame(1'b0, 1'b0, 64, 12, 5, 64);
        idle(4);
        check_frame_counts("gap_mid_line", 1'b0, 64, 1);
    endtask

    task automatic test_back_to_back_mode();
        load_block();
        drive_frame(1'b0, 1'b0, 20, -1, 0, 64);
        drive_frame(1'b0, 1'b1, 64, -1, 0, 64);
        idle(4);
        check_frame_counts("mode_switch", 1'b0, 128, 2);
    endtask

    task automatic test_reset_mid_frame();
        load_block();
        drive_frame(1'b0, 1'b0, 64, -1, 0, 30);
        @(posedge clock);
        #1;
        bus_b.valid_in = 1'b0;
        reset_n        = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        q_b.delete();
        q_g.delete();
        vo_b = 0; eof_b = 0;
        drive_frame(1'b0, 1'b0, 64, -1, 0, 64);
        idle(4);
        check_frame_counts("reset_mid_frame", 1'b0, 64, 1);
    endtask

    initial begin
        reset_n        = 1'b0;
        width          = 16'd8;
        height         = 16'd8;
        mode_b         = 1'b0;
        mode_g         = 1'b0;
        bus_b.valid_in = 1'b0;
        bus_g.valid_in = 1'b0;
        bus_b.p00 = 1'b0; bus_b.p01 = 1'b0; bus_b.p02 = 1'b0;
        bus_b.p10 = 1'b0; bus_b.p11 = 1'b0; bus_b.p12 = 1'b0;
        bus_b.p20 = 1'b0; bus_b.p21 = 1'b0; bus_b.p22 = 1'b0;
        bus_g.p00 = 8'd0; bus_g.p01 = 8'd0; bus_g.p02 = 8'd0;
        bus_g.p10 = 8'd0; bus_g.p11 = 8'd0; bus_g.p12 = 8'd0;
        bus_g.p20 = 8'd0; bus_g.p21 = 8'd0; bus_g.p22 = 8'd0;
        clear_img();

        test_reset();
        test_erode_block();
        test_dilate_point();
        test_gray_minmax();
        test_gap();
        test_back_to_back_mode();
        test_reset_mid_frame();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
